issue_ctrl: RTL and testbench

- Sequences the decode stage: decides each cycle whether the decoded instruction issues to execute, stalls, or is flushed.
- Holds a per-register busy scoreboard, set on issue of a register-writing instruction and cleared on writeback.
- Serialises control flow: after a branch/jump issues, no younger instruction issues until execute resolves it.
- Sits between the decoder/regfile (ID) and the execute stage; drives the fetch and decode stall and flush lines.

---
 rtl/issue_ctrl_pkg.sv | 11 +
 rtl/issue_ctrl_if.sv | 41 ++++
 rtl/issue_ctrl_scoreboard.sv | 60 ++++++
 rtl/issue_ctrl.sv | 83 ++++++++
 tb/tb_issue_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/issue_ctrl_pkg.sv
// Shared types and widths for the decode-stage issue controller.
package issue_ctrl_pkg;
    localparam int REG_ADDR_W  = 5;
    localparam int FLUSH_CNT_W = 3;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        FLUSH   = 2'd2
    } hz_state_t;
endpackage

// File: rtl/issue_ctrl_if.sv
// Decode/execute/writeback signals seen by the issue controller, with ID-side and controller-side views.
interface issue_ctrl_if #(
    parameter int NUM_REGS = 32
);
    import issue_ctrl_pkg::*;

    logic                  id_valid_i;
    logic [REG_ADDR_W-1:0] id_rs1_i;
    logic [REG_ADDR_W-1:0] id_rs2_i;
    logic                  id_rs1_used_i;
    logic                  id_rs2_used_i;
    logic [REG_ADDR_W-1:0] id_rd_i;
    logic                  id_rf_wr_en_i;
    logic                  id_is_branch_i;
    logic                  ex_ready_i;
    logic                  wb_rf_wr_en_i;
    logic [REG_ADDR_W-1:0] wb_rd_i;
    logic                  br_resolve_i;
    logic                  br_taken_i;
    logic                  issue_o;
    logic                  id_stall_o;
    logic                  if_stall_o;
    logic                  flush_o;
    logic [NUM_REGS-1:0]   busy_o;
    logic [1:0]            state_o;
    logic                  err_o;

    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
               id_rd_i, id_rf_wr_en_i, id_is_branch_i, ex_ready_i,
               wb_rf_wr_en_i, wb_rd_i, br_resolve_i, br_taken_i,
        input  issue_o, id_stall_o, if_stall_o, flush_o, busy_o, state_o, err_o
    );

    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
               id_rd_i, id_rf_wr_en_i, id_is_branch_i, ex_ready_i,
               wb_rf_wr_en_i, wb_rd_i, br_resolve_i, br_taken_i,
        output issue_o, id_stall_o, if_stall_o, flush_o, busy_o, state_o, err_o
    );
endinterface

// File: rtl/issue_ctrl_scoreboard.sv
// Per-register busy tracking: hazard lookup for the decoded instruction, set on issue,
// clear on writeback, and a sticky flag for writebacks to registers that were not busy.
module issue_scoreboard
    import issue_ctrl_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int WB_BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic                  rs1_used,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  rs2_used,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  rd_wr,
    output logic                  hazard,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  err
);
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                err_q, err_d;
    logic [NUM_REGS-1:0] set_mask, clr_mask;

    function automatic logic clr_busy(input logic [REG_ADDR_W-1:0] r);
        return wb_en && (wb_rd == r) && (r != '0) && (WB_BYPASS != 0);
    endfunction

    function automatic logic blocked(input logic used, input logic [REG_ADDR_W-1:0] r);
        return used && (r != '0) && busy_q[r] && !clr_busy(r);
    endfunction

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en && set_rd != '0) set_mask[set_rd] = 1'b1;
        if (wb_en && wb_rd != '0)   clr_mask[wb_rd]  = 1'b1;
        // set is applied after clear so a same-cycle reissue keeps the register busy
        busy_d = (busy_q & ~clr_mask) | set_mask;
        err_d  = err_q | (wb_en && wb_rd != '0 && !busy_q[wb_rd]);
        hazard = blocked(rs1_used, rs1) || blocked(rs2_used, rs2) || blocked(rd_wr, rd);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign busy = busy_q;
    assign err  = err_q;
endmodule

// File: rtl/issue_ctrl.sv
// Decode-stage issue control: issue/stall decision, branch serialisation FSM and the
// post-branch flush window.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int WB_BYPASS    = 1
) (
    input  logic          clk,
    input  logic          rst,
    issue_ctrl_if.slave   bus
);
    hz_state_t              state_q, state_d;
    logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
    logic                   hazard;
    logic                   issue;

    issue_scoreboard #(
        .NUM_REGS  (NUM_REGS),
        .WB_BYPASS (WB_BYPASS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue && bus.id_rf_wr_en_i),
        .set_rd   (bus.id_rd_i),
        .wb_en    (bus.wb_rf_wr_en_i),
        .wb_rd    (bus.wb_rd_i),
        .rs1      (bus.id_rs1_i),
        .rs1_used (bus.id_rs1_used_i),
        .rs2      (bus.id_rs2_i),
        .rs2_used (bus.id_rs2_used_i),
        .rd       (bus.id_rd_i),
        .rd_wr    (bus.id_rf_wr_en_i),
        .hazard   (hazard),
        .busy     (bus.busy_o),
        .err      (bus.err_o)
    );

    assign issue = bus.id_valid_i && (state_q == RUN) && bus.ex_ready_i && !hazard;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (issue && bus.id_is_branch_i) state_d = BR_WAIT;
            end
            BR_WAIT: begin
                if (bus.br_resolve_i) begin
                    if (bus.br_taken_i) begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            FLUSH: begin
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // flush dominates: a held decode slot is not reported as a stall while it is being invalidated
    assign bus.issue_o    = issue;
    assign bus.id_stall_o = bus.id_valid_i && !issue && (state_q != FLUSH);
    assign bus.if_stall_o = bus.id_valid_i && !issue && (state_q != FLUSH);
    assign bus.flush_o    = (state_q == FLUSH);
    assign bus.state_o    = state_q;
endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl; a second instance with WB_BYPASS=0 shadows the first for the
// dependency sequence.
module tb_issue_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    issue_ctrl_if #(.NUM_REGS(32)) ifb ();
    issue_ctrl_if #(.NUM_REGS(32)) ifn ();

    issue_ctrl #(.NUM_REGS(32), .FLUSH_CYCLES(2), .WB_BYPASS(1)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb));
    issue_ctrl #(.NUM_REGS(32), .FLUSH_CYCLES(2), .WB_BYPASS(0)) dut_n (
        .clk (clk), .rst (rst), .bus (ifn));

    assign ifn.id_valid_i     = ifb.id_valid_i;
    assign ifn.id_rs1_i       = ifb.id_rs1_i;
    assign ifn.id_rs2_i       = ifb.id_rs2_i;
    assign ifn.id_rs1_used_i  = ifb.id_rs1_used_i;
    assign ifn.id_rs2_used_i  = ifb.id_rs2_used_i;
    assign ifn.id_rd_i        = ifb.id_rd_i;
    assign ifn.id_rf_wr_en_i  = ifb.id_rf_wr_en_i;
    assign ifn.id_is_branch_i = ifb.id_is_branch_i;
    assign ifn.ex_ready_i     = ifb.ex_ready_i;
    assign ifn.wb_rf_wr_en_i  = ifb.wb_rf_wr_en_i;
    assign ifn.wb_rd_i        = ifb.wb_rd_i;
    assign ifn.br_resolve_i   = ifb.br_resolve_i;
    assign ifn.br_taken_i     = ifb.br_taken_i;

    typedef struct {
        string       tag;
        logic        issue;
        logic        stall;
        logic        flush;
        logic [1:0]  state;
        logic [31:0] busy;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   ntest = 0;
    int   nfail = 0;
    logic n_chk = 1'b0;
    logic n_issue, n_stall;

    task automatic cmp(input string tag, input string what, input logic [31:0] got,
                       input logic [31:0] want);
        ntest++;
        assert (got === want) else begin
            nfail++;
            $error("FAIL %s %s got %h want %h", tag, what, got, want);
        end
    endtask

    task automatic idle();
        ifb.id_valid_i = 0; ifb.id_rs1_i = 0; ifb.id_rs2_i = 0;
        ifb.id_rs1_used_i = 0; ifb.id_rs2_used_i = 0; ifb.id_rd_i = 0;
        ifb.id_rf_wr_en_i = 0; ifb.id_is_branch_i = 0; ifb.ex_ready_i = 1;
        ifb.wb_rf_wr_en_i = 0; ifb.wb_rd_i = 0; ifb.br_resolve_i = 0; ifb.br_taken_i = 0;
    endtask

    task automatic instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic wr, input logic br);
        ifb.id_valid_i = 1; ifb.id_rs1_i = rs1; ifb.id_rs1_used_i = u1;
        ifb.id_rs2_i = rs2; ifb.id_rs2_used_i = u2; ifb.id_rd_i = rd;
        ifb.id_rf_wr_en_i = wr; ifb.id_is_branch_i = br;
    endtask

    task automatic wb(input logic [4:0] rd);
        ifb.wb_rf_wr_en_i = 1; ifb.wb_rd_i = rd;
    endtask

    // inputs are already driven; record the expectation, sample on the falling edge, advance one cycle
    task automatic step(input string tag, input logic ei, input logic es, input logic ef,
                        input logic [1:0] est, input logic [31:0] eb, input logic ee);
        exp_t e;
        e.tag = tag; e.issue = ei; e.stall = es; e.flush = ef;
        e.state = est; e.busy = eb; e.err = ee;
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        cmp(e.tag, "issue_o",    32'(ifb.issue_o),    32'(e.issue));
        cmp(e.tag, "id_stall_o", 32'(ifb.id_stall_o), 32'(e.stall));
        cmp(e.tag, "if_stall_o", 32'(ifb.if_stall_o), 32'(e.stall));
        cmp(e.tag, "flush_o",    32'(ifb.flush_o),    32'(e.flush));
        cmp(e.tag, "state_o",    32'(ifb.state_o),    32'(e.state));
        cmp(e.tag, "busy_o",     ifb.busy_o,          e.busy);
        cmp(e.tag, "err_o",      32'(ifb.err_o),      32'(e.err));
        if (n_chk) begin
            cmp({e.tag, "_nobyp"}, "issue_o",    32'(ifn.issue_o),    32'(n_issue));
            cmp({e.tag, "_nobyp"}, "id_stall_o", 32'(ifn.id_stall_o), 32'(n_stall));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        @(posedge clk); #1;
        step("reset", 0, 0, 0, 2'd0, 32'h0, 0);
        rst = 1'b1;

        // back-to-back dependency on x5
        n_chk = 1'b1;
        idle(); instr(5'd0, 1, 5'd0, 0, 5'd5, 1, 0);
        n_issue = 1; n_stall = 0;
        step("dep_addi", 1, 0, 0, 2'd0, 32'h0, 0);
        idle(); instr(5'd5, 1, 5'd5, 1, 5'd6, 1, 0);
        n_issue = 0; n_stall = 1;
        step("dep_stall1", 0, 1, 0, 2'd0, 32'h20, 0);
        step("dep_stall2", 0, 1, 0, 2'd0, 32'h20, 0);
        wb(5'd5);
        step("dep_wb", 1, 0, 0, 2'd0, 32'h20, 0);
        ifb.wb_rf_wr_en_i = 0;
        n_issue = 1; n_stall = 0;
        step("dep_after", 0, 1, 0, 2'd0, 32'h40, 0);
        n_chk = 1'b0;

        rst = 1'b0; idle();
        step("reset_mid", 0, 0, 0, 2'd0, 32'h0, 0);
        rst = 1'b1;

        // x0 never tracked
        idle(); instr(5'd0, 1, 5'd0, 0, 5'd0, 1, 0);
        step("x0_write", 1, 0, 0, 2'd0, 32'h0, 0);
        idle(); instr(5'd0, 1, 5'd0, 1, 5'd1, 1, 0);
        step("x0_read", 1, 0, 0, 2'd0, 32'h0, 0);

        // WAW on x7
        idle(); instr(5'd0, 1, 5'd0, 0, 5'd7, 1, 0);
        step("waw_first", 1, 0, 0, 2'd0, 32'h02, 0);
        step("waw_stall", 0, 1, 0, 2'd0, 32'h82, 0);
        wb(5'd7);
        step("waw_wb", 1, 0, 0, 2'd0, 32'h82, 0);
        idle(); wb(5'd1);
        step("waw_after", 0, 0, 0, 2'd0, 32'h82, 0);

        // taken branch
        idle(); instr(5'd0, 1, 5'd0, 1, 5'd0, 0, 1);
        step("tk_issue", 1, 0, 0, 2'd0, 32'h80, 0);
        idle(); instr(5'd0, 1, 5'd0, 0, 5'd2, 1, 0);
        step("tk_wait", 0, 1, 0, 2'd1, 32'h80, 0);
        ifb.br_resolve_i = 1; ifb.br_taken_i = 1;
        step("tk_resolve", 0, 1, 0, 2'd1, 32'h80, 0);
        ifb.br_resolve_i = 0; ifb.br_taken_i = 0;
        step("tk_flush1", 0, 0, 1, 2'd2, 32'h80, 0);
        step("tk_flush2", 0, 0, 1, 2'd2, 32'h80, 0);
        step("tk_resume", 1, 0, 0, 2'd0, 32'h80, 0);

        // not-taken branch, back-pressure, stray resolve in RUN
        idle(); instr(5'd0, 1, 5'd0, 1, 5'd0, 0, 1);
        step("nt_issue", 1, 0, 0, 2'd0, 32'h84, 0);
        idle(); instr(5'd0, 1, 5'd0, 0, 5'd3, 1, 0);
        ifb.br_resolve_i = 1;
        step("nt_resolve", 0, 1, 0, 2'd1, 32'h84, 0);
        ifb.br_resolve_i = 0;
        step("nt_resume", 1, 0, 0, 2'd0, 32'h84, 0);
        idle(); instr(5'd0, 1, 5'd0, 0, 5'd4, 1, 0);
        ifb.ex_ready_i = 0;
        step("bp_stall", 0, 1, 0, 2'd0, 32'h8C, 0);
        idle(); ifb.br_resolve_i = 1; ifb.br_taken_i = 1;
        step("stray_res", 0, 0, 0, 2'd0, 32'h8C, 0);
        idle();
        step("stray_after", 0, 0, 0, 2'd0, 32'h8C, 0);

        // writeback to a register that is no longer busy
        idle(); wb(5'd3);
        step("err_legal", 0, 0, 0, 2'd0, 32'h8C, 0);
        step("err_bad", 0, 0, 0, 2'd0, 32'h84, 0);
        idle();
        step("err_set", 0, 0, 0, 2'd0, 32'h84, 1);

        // reset while flushing
        idle(); instr(5'd0, 1, 5'd0, 1, 5'd0, 0, 1);
        step("rf_issue", 1, 0, 0, 2'd0, 32'h84, 1);
        idle(); ifb.br_resolve_i = 1; ifb.br_taken_i = 1;
        step("rf_resolve", 0, 0, 0, 2'd1, 32'h84, 1);
        idle();
        step("rf_flush", 0, 0, 1, 2'd2, 32'h84, 1);
        rst = 1'b0;
        step("rf_reset", 0, 0, 0, 2'd0, 32'h0, 0);
        rst = 1'b1;
        step("rf_after", 0, 0, 0, 2'd0, 32'h0, 0);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule
